// File: rtl/fpu_pkg.sv
// FP32 field constants, rounding-mode encoding and the sign/exponent/mantissa
// packing helper shared by the FPU conversion blocks.
package fpu_pkg;

  localparam int EXP_BIAS = 127;
  localparam int MANT_W   = 23;
  localparam int EXP_W    = 8;

  typedef enum logic {
    RM_RNE = 1'b0,
    RM_RTZ = 1'b1
  } rm_e;

  function automatic logic [31:0] fp32_pack(input logic s,
                                            input logic [EXP_W-1:0] e,
                                            input logic [MANT_W-1:0] m);
    return {s, e, m};
  endfunction

endpackage

// File: rtl/lzc.sv
// Parametrised combinational leading-zero counter. count_o equals W when the
// operand is all zero, in which case all_zero_o is also raised.
module lzc #(
  parameter int W  = 32,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  x_i,
  output logic [CW-1:0] count_o,
  output logic          all_zero_o
);

  // Scanning upwards lets the highest set bit have the final say.
  always_comb begin
    count_o = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (x_i[i]) count_o = CW'(W - 1 - i);
    end
  end

  assign all_zero_o = ~|x_i;

endmodule

// File: rtl/itof_pipe.sv
// Pipelined integer -> FP32 converter (RNE/RTZ) with valid/ready backpressure.
// Define ITOF_PIPE_FLAGS_EN to add the out_inexact flag output.
module itof_pipe
  import fpu_pkg::*;
#(
  parameter int IN_W   = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_x,
  input  logic             in_signed,
  input  logic             in_rm,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_y,
  output logic [TAG_W-1:0] out_tag
`ifdef ITOF_PIPE_FLAGS_EN
  ,
  output logic             out_inexact
`endif
);

  localparam int CW = $clog2(IN_W + 1);
  localparam int EW = IN_W + MANT_W + 2;

  // Handshake: a transfer happens on any cycle where valid & ready are both
  // high; valid never waits on ready. The whole pipe moves as one (adv), so
  // every stage holds while a result is presented but not taken.
  logic adv;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  logic            s_c;
  logic [IN_W-1:0] mag_c;
  assign s_c   = in_signed & in_x[IN_W-1];
  assign mag_c = s_c ? -in_x : in_x;

  logic             lz_valid;
  logic             lz_s;
  rm_e              lz_rm;
  logic [TAG_W-1:0] lz_tag;
  logic [IN_W-1:0]  lz_mag;

  if (STAGES == 3) begin : g_split
    logic             a_v_q;
    logic             a_s_q;
    rm_e              a_rm_q;
    logic [TAG_W-1:0] a_tag_q;
    logic [IN_W-1:0]  a_mag_q;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        a_v_q   <= 1'b0;
        a_s_q   <= 1'b0;
        a_rm_q  <= RM_RNE;
        a_tag_q <= '0;
        a_mag_q <= '0;
      end else if (adv) begin
        a_v_q   <= in_valid;
        a_s_q   <= s_c;
        a_rm_q  <= rm_e'(in_rm);
        a_tag_q <= in_tag;
        a_mag_q <= mag_c;
      end
    end

    assign lz_valid = a_v_q;
    assign lz_s     = a_s_q;
    assign lz_rm    = a_rm_q;
    assign lz_tag   = a_tag_q;
    assign lz_mag   = a_mag_q;
  end else begin : g_fused
    assign lz_valid = in_valid;
    assign lz_s     = s_c;
    assign lz_rm    = rm_e'(in_rm);
    assign lz_tag   = in_tag;
    assign lz_mag   = mag_c;
  end

  logic [CW-1:0]    lz_cnt;
  logic             lz_zero;
  logic [IN_W-1:0]  norm_c;
  logic [EXP_W-1:0] exp_c;

  lzc #(.W(IN_W), .CW(CW)) u_lzc (
    .x_i       (lz_mag),
    .count_o   (lz_cnt),
    .all_zero_o(lz_zero)
  );

  // After the shift the leading one (if any) sits at norm_c[IN_W-1].
  assign norm_c = lz_mag << lz_cnt;
  assign exp_c  = lz_zero ? '0 : 8'(EXP_BIAS + IN_W - 1) - 8'(lz_cnt);

  logic             b_v_q;
  logic             b_s_q;
  rm_e              b_rm_q;
  logic [TAG_W-1:0] b_tag_q;
  logic [IN_W-1:0]  b_norm_q;
  logic [EXP_W-1:0] b_exp_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      b_v_q    <= 1'b0;
      b_s_q    <= 1'b0;
      b_rm_q   <= RM_RNE;
      b_tag_q  <= '0;
      b_norm_q <= '0;
      b_exp_q  <= '0;
    end else if (adv) begin
      b_v_q    <= lz_valid;
      b_s_q    <= lz_s;
      b_rm_q   <= lz_rm;
      b_tag_q  <= lz_tag;
      b_norm_q <= norm_c;
      b_exp_q  <= exp_c;
    end
  end

  // Zero padding below the operand makes narrow inputs exact without a
  // special case: guard and sticky simply read as zero.
  logic [EW-1:0]     ext_c;
  logic [MANT_W-1:0] mant_c;
  logic              guard_c;
  logic              sticky_c;
  logic              inc_c;
  logic              carry_c;
  logic [MANT_W-1:0] mant_r_c;
  logic [EXP_W-1:0]  exp_r_c;
  logic [31:0]       y_c;

  assign ext_c    = {b_norm_q, {(MANT_W + 2){1'b0}}};
  assign mant_c   = ext_c[EW-2 -: MANT_W];
  assign guard_c  = ext_c[EW-MANT_W-2];
  assign sticky_c = |ext_c[EW-MANT_W-3:0];
  assign inc_c    = (b_rm_q == RM_RNE) & guard_c & (sticky_c | mant_c[0]);
  assign {carry_c, mant_r_c} = {1'b0, mant_c} + (MANT_W + 1)'(inc_c);
  assign exp_r_c  = b_exp_q + 8'(carry_c);
  assign y_c      = ext_c[EW-1] ? fp32_pack(b_s_q, exp_r_c, mant_r_c) : 32'h0;

  logic             o_v_q;
  logic [31:0]      o_y_q;
  logic [TAG_W-1:0] o_tag_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_v_q   <= 1'b0;
      o_y_q   <= '0;
      o_tag_q <= '0;
    end else if (adv) begin
      o_v_q   <= b_v_q;
      o_y_q   <= y_c;
      o_tag_q <= b_tag_q;
    end
  end

  assign out_valid = o_v_q;
  assign out_y     = o_y_q;
  assign out_tag   = o_tag_q;

`ifdef ITOF_PIPE_FLAGS_EN
  logic o_inexact_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_inexact_q <= 1'b0;
    end else if (adv) begin
      o_inexact_q <= guard_c | sticky_c;
    end
  end

  assign out_inexact = o_inexact_q;
`endif

endmodule

// File: tb/tb_itof_pipe.sv
// Bench for itof_pipe: directed vectors, stall/flush scenarios and random
// sweeps over several IN_W/STAGES configurations against an arithmetic model.
`timescale 1ns/1ps
module tb_itof_pipe;

  localparam int IN_W   = 32;
  localparam int STAGES = 2;
  localparam int TAG_W  = 5;
  localparam int SB_W   = 1 + TAG_W + 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;
  logic g_rstn;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  initial begin
    #900000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Returns {inexact, fp32}; rounding decided by comparing the discarded
  // remainder against half an ulp.
  function automatic logic [32:0] ref_conv(input logic [63:0] xin, input int w,
                                           input logic sgn, input logic rm);
    logic [63:0] mask, x, mag, q, rem, half;
    logic        neg;
    int          p, sh;
    logic [7:0]  e;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    x    = xin & mask;
    neg  = sgn && x[w-1];
    mag  = neg ? ((~x + 64'd1) & mask) : x;
    if (mag == 64'd0) return 33'd0;
    p = 63;
    while (!mag[p]) p--;
    e = 8'(127 + p);
    rem = 64'd0;
    if (p <= 23) begin
      q = mag << (23 - p);
    end else begin
      sh   = p - 23;
      q    = mag >> sh;
      rem  = mag - (q << sh);
      half = 64'd1 << (sh - 1);
      if (!rm && (rem > half || (rem == half && q[0]))) q = q + 64'd1;
      if (q[24]) begin
        q = q >> 1;
        e = e + 8'd1;
      end
    end
    return {(rem != 64'd0), neg, e, q[22:0]};
  endfunction

  function automatic logic [63:0] pick_val();
    logic [63:0] r;
    r = {$urandom, $urandom};
    case ($urandom_range(0, 9))
      0: r = 64'd0;
      1: r = 64'hFFFF_FFFF_FFFF_FFFF;
      2: r = 64'd1 << $urandom_range(0, 63);
      3: r = (64'd1 << $urandom_range(0, 63)) + 64'd1;
      4: r = (64'd1 << $urandom_range(1, 63)) - 64'd1;
      5: r = r >> $urandom_range(0, 63);
      default: ;
    endcase
    return r;
  endfunction

  // ---------------- main DUT ----------------
  logic             in_valid, in_ready, in_signed, in_rm;
  logic [IN_W-1:0]  in_x;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid, out_ready;
  logic [31:0]      out_y;
  logic [TAG_W-1:0] out_tag;
`ifdef ITOF_PIPE_FLAGS_EN
  logic             out_inexact;
`endif

  itof_pipe #(.IN_W(IN_W), .STAGES(STAGES), .TAG_W(TAG_W)) u_dut (
    .clk      (clk),
    .rstn     (rstn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_x     (in_x),
    .in_signed(in_signed),
    .in_rm    (in_rm),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_y    (out_y),
    .out_tag  (out_tag)
`ifdef ITOF_PIPE_FLAGS_EN
    ,
    .out_inexact(out_inexact)
`endif
  );

  // ---------------- scoreboard / monitor ----------------
  logic [SB_W-1:0]  exp_q[$];
  logic             prev_hold = 1'b0;
  logic [31:0]      prev_y;
  logic [TAG_W-1:0] prev_tag;

  always @(negedge clk) begin
    logic [SB_W-1:0] e;
    logic            ok;
    if (!rstn) begin
      prev_hold = 1'b0;
    end else begin
      checks++;
      if (in_ready !== (!out_valid || out_ready)) begin
        failures++;
        $display("FAIL in_ready_rule got=%b out_valid=%b out_ready=%b", in_ready, out_valid, out_ready);
      end
      if (prev_hold) begin
        checks++;
        if (out_valid !== 1'b1 || out_y !== prev_y || out_tag !== prev_tag) begin
          failures++;
          $display("FAIL stall_hold got v=%b y=%h tag=%0d want v=1 y=%h tag=%0d",
                   out_valid, out_y, out_tag, prev_y, prev_tag);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_output got y=%h tag=%0d want none", out_y, out_tag);
        end else begin
          e  = exp_q.pop_front();
          ok = (out_y === e[31:0]) && (out_tag === e[32 +: TAG_W]);
`ifdef ITOF_PIPE_FLAGS_EN
          ok = ok && (out_inexact === e[SB_W-1]);
          if (!ok) $display("FAIL result got y=%h tag=%0d inx=%b want y=%h tag=%0d inx=%b",
                            out_y, out_tag, out_inexact, e[31:0], e[32 +: TAG_W], e[SB_W-1]);
`else
          if (!ok) $display("FAIL result got y=%h tag=%0d want y=%h tag=%0d",
                            out_y, out_tag, e[31:0], e[32 +: TAG_W]);
`endif
          if (!ok) failures++;
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_y    = out_y;
      prev_tag  = out_tag;
    end
  end

  // ---------------- driver tasks ----------------
  int   last_push_cyc;
  logic rand_bp = 1'b0;
  logic [TAG_W-1:0] tag_ctr = '0;

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_bp) out_ready = ($urandom_range(0, 9) < 7);
  end

  // Called at posedge+1; returns at posedge+1 right after the transfer.
  task automatic send(input logic [IN_W-1:0] x, input logic sgn, input logic rm,
                      input logic [TAG_W-1:0] tag, input logic [32:0] e);
    int waitc;
    in_valid = 1'b1; in_x = x; in_signed = sgn; in_rm = rm; in_tag = tag;
    @(negedge clk);
    waitc = 0;
    while (!in_ready && waitc < 300) begin
      @(negedge clk);
      waitc++;
    end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL in_ready_timeout got in_ready=0 want 1 within 300 cycles");
      in_valid = 1'b0;
    end else begin
      exp_q.push_back({e[32], tag, e[31:0]});
    end
    last_push_cyc = cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic send_ref(input logic [IN_W-1:0] x, input logic sgn, input logic rm,
                          input logic [TAG_W-1:0] tag);
    send(x, sgn, rm, tag, ref_conv(64'(x), IN_W, sgn, rm));
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int waitc;
    waitc = 0;
    while (exp_q.size() != 0 && waitc < 2000) begin
      @(negedge clk);
      waitc++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout got pending=%0d want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Single op into an idle pipe with the consumer ready; also checks latency.
  task automatic single(input logic [IN_W-1:0] x, input logic sgn, input logic rm,
                        input logic [31:0] y, input logic inx);
    int waitc, lat;
    tag_ctr = tag_ctr + 1'b1;
    send(x, sgn, rm, tag_ctr, {inx, y});
    idle();
    waitc = 0;
    @(negedge clk);
    while (!out_valid && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    lat = cyc - last_push_cyc;
    checks++;
    if (lat != STAGES) begin
      failures++;
      $display("FAIL latency x=%h got=%0d want=%0d", x, lat, STAGES);
    end
    drain();
    @(posedge clk);
    #1;
  endtask

  // ---------------- extra configurations (random sweep) ----------------
  function automatic int cfg_w(input int g);
    case (g)
      0: return 16;
      1: return 16;
      2: return 32;
      3: return 64;
      default: return 64;
    endcase
  endfunction

  function automatic int cfg_s(input int g);
    case (g)
      0: return 2;
      1: return 3;
      2: return 3;
      3: return 2;
      default: return 3;
    endcase
  endfunction

  for (genvar g = 0; g < 5; g++) begin : g_cfg
    localparam int W = cfg_w(g);
    localparam int S = cfg_s(g);
    logic             v, rdy, s, rm, ov, ordy;
    logic [W-1:0]     x;
    logic [TAG_W-1:0] tg, otg;
    logic [31:0]      oy;
    logic             done = 1'b0;
    logic [SB_W-1:0]  q[$];
`ifdef ITOF_PIPE_FLAGS_EN
    logic             oinx;
`endif

    itof_pipe #(.IN_W(W), .STAGES(S), .TAG_W(TAG_W)) u_dut (
      .clk      (clk),
      .rstn     (g_rstn),
      .in_valid (v),
      .in_ready (rdy),
      .in_x     (x),
      .in_signed(s),
      .in_rm    (rm),
      .in_tag   (tg),
      .out_valid(ov),
      .out_ready(ordy),
      .out_y    (oy),
      .out_tag  (otg)
`ifdef ITOF_PIPE_FLAGS_EN
      ,
      .out_inexact(oinx)
`endif
    );

    initial begin
      v = 1'b0; x = '0; s = 1'b0; rm = 1'b0; tg = '0; ordy = 1'b1;
      @(posedge g_rstn);
      @(posedge clk);
      #1;
      fork
        forever begin
          @(posedge clk);
          #1;
          ordy = ($urandom_range(0, 9) < 6);
        end
      join_none
      for (int n = 0; n < 300; n++) begin
        logic [32:0] e;
        int          waitc;
        x  = W'(pick_val());
        s  = 1'($urandom_range(0, 1));
        rm = 1'($urandom_range(0, 1));
        tg = TAG_W'(n);
        v  = 1'b1;
        @(negedge clk);
        waitc = 0;
        while (!rdy && waitc < 300) begin
          @(negedge clk);
          waitc++;
        end
        if (!rdy) begin
          checks++; failures++;
          $display("FAIL cfg%0d_in_ready_timeout got 0 want 1", g);
          break;
        end
        e = ref_conv(64'(x), W, s, rm);
        q.push_back({e[32], tg, e[31:0]});
        @(posedge clk);
        #1;
        v = 1'b0;
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
      end
      v = 1'b0;
      for (int k = 0; k < 3000 && q.size() != 0; k++) @(negedge clk);
      checks++;
      if (q.size() != 0) begin
        failures++;
        $display("FAIL cfg%0d_drain got pending=%0d want 0", g, q.size());
      end
      done = 1'b1;
    end

    always @(negedge clk) begin
      logic [SB_W-1:0] e;
      logic            ok;
      if (g_rstn && ov && ordy) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL cfg%0d_unexpected got y=%h want none", g, oy);
        end else begin
          e  = q.pop_front();
          ok = (oy === e[31:0]) && (otg === e[32 +: TAG_W]);
`ifdef ITOF_PIPE_FLAGS_EN
          ok = ok && (oinx === e[SB_W-1]);
`endif
          if (!ok) begin
            failures++;
            $display("FAIL cfg%0d_result W=%0d S=%0d got y=%h tag=%0d want y=%h tag=%0d",
                     g, W, S, oy, otg, e[31:0], e[32 +: TAG_W]);
          end
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int waitc;
    rstn = 1'b0; g_rstn = 1'b0;
    in_valid = 1'b0; in_x = '0; in_signed = 1'b0; in_rm = 1'b0; in_tag = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1; g_rstn = 1'b1;
    @(negedge clk);
    checks += 4;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
    if (out_y !== 32'h0)    begin failures++; $display("FAIL rst_out_y got=%h want=0", out_y); end
    if (out_tag !== '0)     begin failures++; $display("FAIL rst_out_tag got=%h want=0", out_tag); end
    if (in_ready !== 1'b1)  begin failures++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
    @(posedge clk);
    #1;

    single(32'h7FFF_FFFF, 1'b1, 1'b0, 32'h4F00_0000, 1'b1);
    single(32'hFFFF_FFFF, 1'b1, 1'b0, 32'hBF80_0000, 1'b0);
    single(32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b0);
    single(32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b0);
    single(32'h8000_0000, 1'b1, 1'b0, 32'hCF00_0000, 1'b0);
    single(32'h8000_0000, 1'b0, 1'b0, 32'h4F00_0000, 1'b0);
    single(32'h0100_0001, 1'b1, 1'b0, 32'h4B80_0000, 1'b1);
    single(32'h0100_0001, 1'b1, 1'b1, 32'h4B80_0000, 1'b1);
    single(32'h0100_0003, 1'b1, 1'b0, 32'h4B80_0002, 1'b1);
    single(32'h0100_0003, 1'b1, 1'b1, 32'h4B80_0001, 1'b1);

    // Back-to-back burst, consumer stalls during cycles 3..5.
    fork
      begin
        for (int t = 1; t <= 8; t++)
          send_ref(IN_W'(pick_val()), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), TAG_W'(t));
        idle();
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (!(out_valid === 1'b1 && in_ready === 1'b0)) begin
          failures++;
          $display("FAIL burst_full got out_valid=%b in_ready=%b want 1/0", out_valid, in_ready);
        end
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    @(posedge clk);
    #1;

    // Flush with two operations in flight.
    send_ref(32'h0000_1234, 1'b0, 1'b0, 5'd20);
    send_ref(32'hFFFF_0000, 1'b1, 1'b0, 5'd21);
    idle();
    #1;
    rstn = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_out_valid got=%b want=0", out_valid);
    end
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2;
    rstn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL flush_stale got out_valid=%b y=%h want 0", out_valid, out_y);
      end
    end
    @(posedge clk);
    #1;
    single(32'h0000_0005, 1'b1, 1'b0, 32'h40A0_0000, 1'b0);

    // Random sweep with random backpressure.
    rand_bp = 1'b1;
    for (int n = 0; n < 400; n++) begin
      send_ref(IN_W'(pick_val()), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), TAG_W'(n));
      if ($urandom_range(0, 3) == 0) begin
        idle();
        @(posedge clk);
        #1;
      end
    end
    idle();
    drain();
    rand_bp = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    waitc = 0;
    while (!(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done && g_cfg[3].done && g_cfg[4].done)
           && waitc < 20000) begin
      @(negedge clk);
      waitc++;
    end
    checks++;
    if (!(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done && g_cfg[3].done && g_cfg[4].done)) begin
      failures++;
      $display("FAIL sweep_timeout got unfinished configs want all done");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
